mem_if: RTL
===========

Name: mem_if

Overview:
Memory interface unit directly downstream of the multi-cycle control FSM and datapath. It accepts single-cycle read/write requests (enable, address, access size, store data) and converts them into a word-aligned bus transaction with byte enables. It waits for the bus acknowledge and returns LSB-aligned, zero-extended read data. It drives the busy (halt) and error signals consumed by control.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles in BUSY without bus_ack_i before a timeout error; must be >= 1.

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
rd_enable_i  in  1  read request, one-cycle pulse
rd_size_i  in  mem_access_size_t  read size (BYTE/HALF/WORD)
rd_addr_i  in  32  read byte address
wr_enable_i  in  1  write request, one-cycle pulse
wr_size_i  in  mem_access_size_t  write size
wr_addr_i  in  32  write byte address
wr_data_i  in  32  store data, LSB-aligned
rd_data_o  out  32  read result, LSB-aligned, zero-extended
busy_o  out  1  transaction in flight (control halt)
error_o  out  1  sticky error flag
bus_req_o  out  1  bus request
bus_we_o  out  1  1 = write
bus_addr_o  out  32  word address, byte address with bits [1:0] = 0
bus_be_o  out  4  byte lane enables
bus_wdata_o  out  32  lane-shifted write data
bus_rdata_i  in  32  bus read data, valid with ack
bus_ack_i  in  1  transaction complete
bus_err_i  in  1  bus error, valid with ack

Behaviour:
- Clock and reset: single clock clk_i. Reset is synchronous and active-high on reset_i.
- Reset values: state IDLE; all outputs 0 (rd_data_o=0, busy_o=0, error_o=0, bus_* = 0); timeout counter 0.
- States: IDLE, BUSY, ERROR.
- IDLE with exactly one of rd_enable_i / wr_enable_i high: check alignment.
  - Aligned: latch addr[1:0], size, direction, bus address, be and wdata. Go to BUSY next cycle.
  - Misaligned (HALF with addr[0]=1; WORD with addr[1:0]!=0): go to ERROR next cycle. No bus_req_o is ever raised.
- IDLE with both enables high: go to ERROR (protocol violation).
- IDLE with neither enable high: stay in IDLE.
- BUSY:
  - bus_req_o=1 and busy_o=1. bus_addr/we/be/wdata are held stable from registers.
  - Counter increments every cycle.
  - On bus_ack_i=1 with bus_err_i=0: go to IDLE next cycle. For reads, rd_data_o is loaded at that same edge.
  - On bus_ack_i=1 with bus_err_i=1: go to ERROR.
  - If the counter reaches TIMEOUT_CYCLES with no ack: go to ERROR and drop bus_req_o.
- busy_o is a function of state only (BUSY), not of bus_ack_i.
  - Request in cycle N: busy_o=1 from N+1 through the ack cycle, 0 the cycle after.
  - Minimum latency request-to-busy-low is 2 cycles (ack in N+1 → busy_o=0 in N+2).
- Requests arriving while in BUSY or ERROR are ignored.
- ERROR: error_o=1, busy_o=0, bus_req_o=0. ERROR is absorbing; only reset_i exits it.
- Byte enables (o = addr[1:0]):
  - BYTE: 4'b0001<<o.
  - HALF: 4'b0011<<o.
  - WORD: 4'b1111.
- Write data: bus_wdata_o = wr_data_i << (8*o), masked to the enabled lanes (other lanes 0).
- Read data: rd_data_o = (bus_rdata_i >> 8*o), masked to 8/16/32 bits and zero-extended. Sign extension is done in the datapath.
- rd_data_o holds its value until the next successful read. Writes and errors do not change it.
- Reset while BUSY: the transaction is abandoned and bus_req_o=0 the cycle after reset is sampled. A late bus_ack_i arriving in IDLE is ignored.
- An ack in the same cycle the counter hits TIMEOUT_CYCLES: the ack wins, no error.

Test Plan:
- LW 0x0000_0100, ack after 3 cycles with rdata 0xDEADBEEF → busy_o=1 for exactly 3 cycles; bus_be_o=4'hF, bus_addr_o=0x100; then rd_data_o=0xDEADBEEF, busy_o=0.
- LB 0x0000_0203 with rdata 0xAABBCCDD → bus_addr_o=0x200, be=4'b1000, rd_data_o=0x0000_00AA. LHU 0x202 with the same rdata → rd_data_o=0x0000_AABB.
- SH 0x0000_0102, wr_data_i=0xFFFF_1234, ack after 1 cycle → bus_we_o=1, be=4'b1100, bus_wdata_o=0x1234_0000, rd_data_o unchanged, busy_o low 2 cycles after request.
- Misaligned LW 0x101 → error_o=1 next cycle and stays 1; bus_req_o never asserted; a later valid request is ignored.
- TIMEOUT_CYCLES=4, no ack → error_o=1 after 4 BUSY cycles, bus_req_o drops. Separately, ack with bus_err_i=1 → error_o=1.
- Reset asserted mid-BUSY (cycle 2) → bus_req_o=0 and busy_o=0 next cycle; an ack in the following cycle causes no rd_data_o change and no error.

Source files
------------

// File: rtl/mem_if.sv
// mem_if: converts single-cycle load/store requests from the control FSM into a
// word-aligned bus transaction with byte-lane enables, waits for the bus
// acknowledge and returns LSB-aligned, zero-extended read data.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   rd_enable_i/size/addr   read request (one-cycle pulse)
//   wr_enable_i/size/addr   write request (one-cycle pulse)
//   wr_data_i               store data, LSB-aligned
//   rd_data_o               last successful read result, zero-extended
//   busy_o                  transaction in flight (halts control)
//   error_o                 sticky error, cleared only by reset
//   bus_*                   word-addressed bus with byte enables and ack/err
//
// State table
//   state | meaning
//   IDLE  | waiting for a request
//   BUSY  | bus request outstanding, waiting for ack or timeout
//   ERROR | misalignment, protocol violation, bus error or timeout; absorbing

package mem_if_pkg;
   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_access_size_t;
endpackage

module mem_if
   import mem_if_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              rd_enable_i,
   input  mem_access_size_t  rd_size_i,
   input  logic [31:0]       rd_addr_i,
   input  logic              wr_enable_i,
   input  mem_access_size_t  wr_size_i,
   input  logic [31:0]       wr_addr_i,
   input  logic [31:0]       wr_data_i,
   output logic [31:0]       rd_data_o,
   output logic              busy_o,
   output logic              error_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [31:0]       bus_addr_o,
   output logic [3:0]        bus_be_o,
   output logic [31:0]       bus_wdata_o,
   input  logic [31:0]       bus_rdata_i,
   input  logic              bus_ack_i,
   input  logic              bus_err_i
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ERROR = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [CNT_W-1:0]  cnt_q;
   logic [1:0]        off_q;
   mem_access_size_t  size_q;
   logic              we_q;
   logic [31:0]       addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rd_data_q;

   logic              req_rd, req_wr, req_both;
   mem_access_size_t  req_size;
   logic [31:0]       req_addr;
   logic [1:0]        req_off;
   logic              req_misaligned;
   logic [3:0]        req_be;
   logic [31:0]       req_lane_mask;
   logic [31:0]       req_wdata;
   logic              accept;
   logic              timeout_hit;
   logic [31:0]       rdata_shift;
   logic [31:0]       rdata_ext;

   // Request decode: only one enable may be high for a legal request.
   assign req_rd   = rd_enable_i & ~wr_enable_i;
   assign req_wr   = wr_enable_i & ~rd_enable_i;
   assign req_both = rd_enable_i & wr_enable_i;
   assign req_size = req_wr ? wr_size_i : rd_size_i;
   assign req_addr = req_wr ? wr_addr_i : rd_addr_i;
   assign req_off  = req_addr[1:0];

   always_comb begin
      req_misaligned = 1'b0;
      req_be         = 4'b0000;
      case (req_size)
         MEM_BYTE: req_be = 4'b0001 << req_off;
         MEM_HALF: begin
            req_be         = 4'b0011 << req_off;
            req_misaligned = req_off[0];
         end
         MEM_WORD: begin
            req_be         = 4'b1111;
            req_misaligned = (req_off != 2'b00);
         end
         default: req_misaligned = 1'b1;
      endcase
   end

   assign req_lane_mask = {{8{req_be[3]}}, {8{req_be[2]}}, {8{req_be[1]}}, {8{req_be[0]}}};
   assign req_wdata     = (wr_data_i << {req_off, 3'b000}) & req_lane_mask;
   assign accept        = (state_q == IDLE) & (req_rd | req_wr) & ~req_misaligned;

   // Counter holds the number of completed BUSY cycles; the last permitted
   // cycle is the one where it equals TIMEOUT_CYCLES-1.
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_both)
               state_d = ERROR;
            else if (req_rd | req_wr)
               state_d = req_misaligned ? ERROR : BUSY;
         end
         BUSY: begin
            // An ack in the timeout cycle takes priority over the timeout.
            if (bus_ack_i)
               state_d = bus_err_i ? ERROR : IDLE;
            else if (timeout_hit)
               state_d = ERROR;
         end
         ERROR:   state_d = ERROR;
         default: state_d = ERROR;
      endcase
   end

   assign rdata_shift = bus_rdata_i >> {off_q, 3'b000};

   always_comb begin
      rdata_ext = rdata_shift;
      case (size_q)
         MEM_BYTE: rdata_ext = {24'h0, rdata_shift[7:0]};
         MEM_HALF: rdata_ext = {16'h0, rdata_shift[15:0]};
         default:  rdata_ext = rdata_shift;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         off_q     <= 2'b00;
         size_q    <= MEM_BYTE;
         we_q      <= 1'b0;
         addr_q    <= 32'h0;
         be_q      <= 4'h0;
         wdata_q   <= 32'h0;
         rd_data_q <= 32'h0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q   <= '0;
            off_q   <= req_off;
            size_q  <= req_size;
            we_q    <= req_wr;
            addr_q  <= {req_addr[31:2], 2'b00};
            be_q    <= req_be;
            wdata_q <= req_wr ? req_wdata : 32'h0;
         end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if ((state_q == BUSY) && bus_ack_i && !bus_err_i && !we_q)
            rd_data_q <= rdata_ext;
      end
   end

   assign rd_data_o   = rd_data_q;
   assign busy_o      = (state_q == BUSY);
   assign bus_req_o   = (state_q == BUSY);
   assign error_o     = (state_q == ERROR);
   assign bus_we_o    = we_q;
   assign bus_addr_o  = addr_q;
   assign bus_be_o    = be_q;
   assign bus_wdata_o = wdata_q;

endmodule
